// File: rtl/mhp_tx_if.sv
// Byte-stream bundle for the MHP transmit framer: upstream payload source and eth TX write side.
interface mhp_tx_if;
    logic [7:0] pdata;
    logic       pvalid;
    logic       pready;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;

    modport master (
        input  pdata, pvalid, wready,
        output pready, wdata, wvalid
    );

    modport slave (
        output pdata, pvalid, wready,
        input  pready, wdata, wvalid
    );
endinterface

// File: rtl/mhp_tx.sv
// MHP transmit framer: serialises a 7-byte header, streams the payload, appends a 16-bit sum checksum.
module mhp_tx #(
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned LEN_W   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_send,
    input  logic [15:0] i_dst,
    input  logic [15:0] i_src,
    input  logic [15:0] i_size,
    input  logic [7:0]  i_d_type,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    mhp_tx_if.master    bus
);

    localparam int unsigned IDX_W    = 3;
    localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(6);

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAY, ST_SCS, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        dst_q, dst_d, src_q, src_d, size_q, size_d, scs_q, scs_d;
    logic [7:0]         dtype_q, dtype_d, wdata_q, wdata_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               wvalid_q, wvalid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               load_ok, pready_c;
    logic [7:0]         hdr_byte;

    // The output register may take a new byte when empty or when its byte leaves this cycle.
    assign load_ok = !wvalid_q || bus.wready;

    always_comb begin
        case (idx_q)
            IDX_W'(1): hdr_byte = dst_q[7:0];
            IDX_W'(2): hdr_byte = src_q[15:8];
            IDX_W'(3): hdr_byte = src_q[7:0];
            IDX_W'(4): hdr_byte = size_q[15:8];
            IDX_W'(5): hdr_byte = size_q[7:0];
            IDX_W'(6): hdr_byte = dtype_q;
            default:   hdr_byte = dst_q[15:8];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dst_d    = dst_q;
        src_d    = src_q;
        size_d   = size_q;
        dtype_d  = dtype_q;
        scs_d    = scs_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        wvalid_d = wvalid_q && !bus.wready;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        pready_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // busy_q here means the done cycle of the previous request: sends are ignored.
                if (i_send && !busy_q) begin
                    busy_d = 1'b1;
                    if (i_size > 16'(MAX_LEN)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        dst_d    = i_dst;
                        src_d    = i_src;
                        size_d   = i_size;
                        dtype_d  = i_d_type;
                        cnt_d    = '0;
                        wdata_d  = i_dst[15:8];
                        wvalid_d = 1'b1;
                        scs_d    = {8'h00, i_dst[15:8]};
                        idx_d    = IDX_W'(1);
                        state_d  = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (load_ok) begin
                    wdata_d  = hdr_byte;
                    wvalid_d = 1'b1;
                    scs_d    = scs_q + {8'h00, hdr_byte};
                    idx_d    = idx_q + IDX_W'(1);
                    if (idx_q == HDR_LAST) begin
                        idx_d   = '0;
                        state_d = (size_q == 16'd0) ? ST_SCS : ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                pready_c = load_ok && (16'(cnt_q) != size_q);
                if (pready_c && bus.pvalid) begin
                    wdata_d  = bus.pdata;
                    wvalid_d = 1'b1;
                    scs_d    = scs_q + {8'h00, bus.pdata};
                    cnt_d    = cnt_q + LEN_W'(1);
                    if ((16'(cnt_q) + 16'd1) == size_q) begin
                        state_d = ST_SCS;
                    end
                end
            end
            ST_SCS: begin
                if (load_ok) begin
                    wvalid_d = 1'b1;
                    if (idx_q == '0) begin
                        wdata_d = scs_q[15:8];
                        idx_d   = IDX_W'(1);
                    end else begin
                        wdata_d = scs_q[7:0];
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // load_ok here means the last checksum byte is leaving.
                if (load_ok) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            dst_q    <= '0;
            src_q    <= '0;
            size_q   <= '0;
            dtype_q  <= '0;
            scs_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            size_q   <= size_d;
            dtype_q  <= dtype_d;
            scs_q    <= scs_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.wdata  = wdata_q;
    assign bus.wvalid = wvalid_q;
    assign bus.pready = pready_c;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule
